vga_sync_decoder: RTL and testbench

Receive-side counterpart of the 640x480 VGA timing generator: it watches the hsync/vsync pair, plus the 25 MHz pixel-enable tick, and rebuilds the pixel coordinates from them. It checks line and frame timing against the 640x480 parameters and reports lock and error status. Consumers (overlay, video capture, self-test) get pixel_x/pixel_y and video_on without a direct connection to the generator's counters.

---
 rtl/vga_sync_decoder.sv | 169 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Rebuilds VGA pixel coordinates from hsync/vsync/p_tick and tracks lock by
// checking line period, hsync width and frame length against the timing parameters.
//
// state  | meaning
// SEARCH | waiting for the first hsync rise
// HLINE  | one hsync rise seen, measuring a full line period
// VWAIT  | line period good, waiting for the first vsync rise
// VFRAME | measuring a full frame between vsync rises
// LOCKED | line and frame timing confirmed, outputs valid
module vga_sync_decoder #(
  parameter int H_DISPLAY    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_RETRACE    = 96,
  parameter int H_TOTAL      = 800,
  parameter int V_DISPLAY    = 480,
  parameter int V_SYNC_START = 513,
  parameter int V_TOTAL      = 525
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err
);

  typedef enum logic [2:0] {
    SEARCH = 3'd0,
    HLINE  = 3'd1,
    VWAIT  = 3'd2,
    VFRAME = 3'd3,
    LOCKED = 3'd4
  } state_t;

  localparam logic [9:0] H_DISP   = 10'(H_DISPLAY);
  localparam logic [9:0] H_SS1    = 10'(H_SYNC_START + 1);
  localparam logic [9:0] H_RET    = 10'(H_RETRACE);
  localparam logic [9:0] H_TOT    = 10'(H_TOTAL);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_DISP   = 10'(V_DISPLAY);
  localparam logic [9:0] V_SS     = 10'(V_SYNC_START);
  localparam logic [9:0] V_TOT    = 10'(V_TOTAL);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] CNT_MAX  = 10'd1023;

  state_t     state, state_next;
  logic       hs_prev, vs_prev;
  logic [9:0] line_cnt, hw_cnt, fl_cnt;
  logic [9:0] h_next, v_next;
  logic       hs_rise, hs_fall, vs_rise;
  logic       period_ok, width_ok, frame_ok;
  logic       err;

  assign hs_rise   = p_tick & hsync & ~hs_prev;
  assign hs_fall   = p_tick & ~hsync & hs_prev;
  assign vs_rise   = p_tick & vsync & ~vs_prev;
  assign period_ok = (line_cnt == H_TOT);
  assign width_ok  = (hw_cnt == H_RET);
  assign frame_ok  = (fl_cnt == V_TOT);

  always_comb begin
    h_next = pixel_x;
    if (hs_rise)
      h_next = H_SS1;
    else if (p_tick)
      h_next = (pixel_x == H_LAST) ? 10'd0 : pixel_x + 10'd1;
  end

  // vsync realignment wins over the end-of-line row advance
  always_comb begin
    v_next = pixel_y;
    if (vs_rise)
      v_next = V_SS;
    else if (p_tick && pixel_x == H_LAST)
      v_next = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
  end

  always_comb begin
    state_next = state;
    err        = 1'b0;
    if (state == SEARCH) begin
      if (hs_rise)
        state_next = HLINE;
    end else if (line_cnt == CNT_MAX) begin
      err        = 1'b1;
      state_next = SEARCH;
    end else if (hs_rise && !period_ok) begin
      err        = 1'b1;
      state_next = HLINE;
    end else if (hs_fall && !width_ok) begin
      err        = 1'b1;
      state_next = HLINE;
    end else begin
      unique case (state)
        HLINE:   if (hs_rise) state_next = VWAIT;
        VWAIT:   if (vs_rise) state_next = VFRAME;
        VFRAME: begin
          if (vs_rise) begin
            if (frame_ok) state_next = LOCKED;
            else          err        = 1'b1;
          end
        end
        LOCKED: begin
          if (vs_rise && !frame_ok) begin
            err        = 1'b1;
            state_next = VFRAME;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SEARCH;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      line_cnt    <= 10'd0;
      hw_cnt      <= 10'd0;
      fl_cnt      <= 10'd0;
      pixel_x     <= 10'd0;
      pixel_y     <= 10'd0;
      video_on    <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (p_tick) begin
        hs_prev <= hsync;
        vs_prev <= vsync;
      end

      if (hs_rise)
        line_cnt <= 10'd1;
      else if (p_tick && line_cnt != CNT_MAX)
        line_cnt <= line_cnt + 10'd1;

      if (hs_rise)
        hw_cnt <= 10'd1;
      else if (p_tick && hsync)
        hw_cnt <= hw_cnt + 10'd1;

      // a vsync rise coinciding with an hsync rise already counts that line
      if (vs_rise)
        fl_cnt <= hs_rise ? 10'd1 : 10'd0;
      else if (hs_rise)
        fl_cnt <= fl_cnt + 10'd1;

      pixel_x     <= h_next;
      pixel_y     <= v_next;
      locked      <= (state_next == LOCKED);
      video_on    <= (state_next == LOCKED) && (h_next < H_DISP) && (v_next < V_DISP);
      frame_start <= (state_next == LOCKED) && (h_next == 10'd0) && (v_next == 10'd0) &&
                     ((pixel_x != 10'd0) || (pixel_y != 10'd0));
      sync_err    <= err;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a scaled-down generator drives the decoder, with
// a table of injected timing faults plus hand-written lock and reset sequences.
module tb_vga_sync_decoder;

  localparam int HD  = 8;
  localparam int HSS = 10;
  localparam int HR  = 3;
  localparam int HT  = 16;
  localparam int VD  = 4;
  localparam int VSS = 6;
  localparam int VT  = 9;
  localparam int FRAME_CLK = HT * VT * 2;

  localparam int F_STRETCH = 1;
  localparam int F_NARROW  = 2;
  localparam int F_HOLD    = 3;
  localparam int F_SHORT   = 4;

  logic       clk = 1'b0;
  logic       reset, p_tick, hsync, vsync;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, locked, frame_start, sync_err;

  vga_sync_decoder #(
    .H_DISPLAY(HD), .H_SYNC_START(HSS), .H_RETRACE(HR), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_SYNC_START(VSS), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on), .locked(locked),
    .frame_start(frame_start), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int gh, gv;
  bit run, stretch_line, narrow_line, short_frame, hs_mask, vs_mask, trk, xtrk;
  int err_cnt, err_state, fs_cnt, trk_bad, x_bad, lo_cnt;
  int passed, total;

  typedef struct {
    string name;
    int    fault;
    int    exp_errs;
    int    exp_state;
    int    max_low;
    int    exact_low;
  } scen_t;
  scen_t scen[4];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // one clk: sample at negedge, advance the generator model, drive next inputs
  task automatic tick();
    bit adv, exp_vo, exp_fs;
    int ht, vt, hw;
    @(negedge clk);
    adv = run && p_tick;
    ht  = stretch_line ? HT + 1 : HT;
    vt  = short_frame ? VT - 1 : VT;
    if (adv) begin
      if (gh == ht - 1) begin
        gh = 0;
        stretch_line = 0;
        narrow_line  = 0;
        if (gv == vt - 1) begin
          gv = 0;
          short_frame = 0;
        end else gv++;
      end else gh++;
    end
    if (sync_err) begin
      err_cnt++;
      if (err_state < 0) err_state = int'(dut.state);
    end
    if (frame_start) fs_cnt++;
    if (!locked) lo_cnt++;
    if (xtrk && pixel_x != 10'(gh)) x_bad++;
    if (trk) begin
      exp_vo = (gh < HD) && (gv < VD);
      exp_fs = adv && gh == 0 && gv == 0;
      if (pixel_x != 10'(gh) || pixel_y != 10'(gv) || video_on != exp_vo || frame_start != exp_fs) begin
        if (trk_bad < 3)
          $display("track diff at gen (%0d,%0d): x=%0d y=%0d vo=%0b fs=%0b", gh, gv,
                   pixel_x, pixel_y, video_on, frame_start);
        trk_bad++;
      end
    end
    p_tick = run ? ~p_tick : 1'b0;
    hw     = narrow_line ? HR - 1 : HR;
    hsync  = !hs_mask && gh >= HSS && gh < HSS + hw;
    vsync  = !vs_mask && gv >= VSS && gv < VSS + 2;
  endtask

  task automatic wait_locked(input string name, input int budget);
    int n = 0;
    while (!locked && n < budget) begin
      tick();
      n++;
    end
    check(name, int'(locked), 1);
  endtask

  task automatic wait_origin(input string name);
    int n = 0;
    while (!(gh == 0 && gv == 0) && n < 2 * FRAME_CLK) begin
      tick();
      n++;
    end
    check(name, int'(gh == 0 && gv == 0), 1);
  endtask

  task automatic track_two_frames(input string name);
    trk_bad = 0;
    fs_cnt  = 0;
    err_cnt = 0;
    trk     = 1;
    repeat (2 * FRAME_CLK) tick();
    trk = 0;
    check({name, "_track_diffs"}, trk_bad, 0);
    check({name, "_frame_starts"}, fs_cnt, 2);
    check({name, "_errs"}, err_cnt, 0);
  endtask

  initial begin
    int n;
    scen[0] = '{"stretch", F_STRETCH, 1, 1, 2 * FRAME_CLK, 0};
    scen[1] = '{"narrow",  F_NARROW,  1, 1, 2 * FRAME_CLK, 0};
    scen[2] = '{"hold",    F_HOLD,    1, 0, 4000,          0};
    scen[3] = '{"short",   F_SHORT,   1, 3, 2 * FRAME_CLK, FRAME_CLK};

    passed = 0; total = 0;
    gh = 0; gv = 0; run = 0;
    stretch_line = 0; narrow_line = 0; short_frame = 0;
    hs_mask = 0; vs_mask = 0; trk = 0; xtrk = 0;
    err_cnt = 0; err_state = -1; fs_cnt = 0; trk_bad = 0; x_bad = 0; lo_cnt = 0;
    reset = 1'b1; p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0;

    repeat (3) tick();
    check("rst_pixel_x", int'(pixel_x), 0);
    check("rst_pixel_y", int'(pixel_y), 0);
    check("rst_video_on", int'(video_on), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_sync_err", int'(sync_err), 0);

    reset = 1'b0;
    run   = 1;
    n = 0;
    while (gh != HSS + 1 && n < 100) begin
      tick();
      n++;
    end
    check("first_rise_x", int'(pixel_x), HSS + 1);
    xtrk = 1;
    wait_locked("initial_lock", 3 * FRAME_CLK - n);
    xtrk = 0;
    check("x_track_before_lock", x_bad, 0);
    check("no_err_during_lock", err_cnt, 0);
    track_two_frames("clean");

    for (int i = 0; i < 4; i++) begin
      wait_locked({scen[i].name, "_locked_before"}, 3 * FRAME_CLK);
      wait_origin({scen[i].name, "_origin"});
      err_cnt = 0; err_state = -1; lo_cnt = 0;
      case (scen[i].fault)
        F_STRETCH: stretch_line = 1;
        F_NARROW:  narrow_line  = 1;
        F_SHORT:   short_frame  = 1;
        F_HOLD: begin
          // vsync is held too so only the line watchdog can fire
          hs_mask = 1;
          vs_mask = 1;
          repeat (1100 * 2) tick();
          check("hold_video_off", int'(video_on), 0);
          check("hold_locked_off", int'(locked), 0);
          wait_origin("hold_release");
          hs_mask = 0;
          vs_mask = 0;
        end
        default: ;
      endcase
      repeat (3 * FRAME_CLK) tick();
      check({scen[i].name, "_errs"}, err_cnt, scen[i].exp_errs);
      check({scen[i].name, "_state"}, err_state, scen[i].exp_state);
      check({scen[i].name, "_relocked"}, int'(locked), 1);
      if (scen[i].exact_low > 0)
        check({scen[i].name, "_low_clks"}, lo_cnt, scen[i].exact_low);
      else
        check({scen[i].name, "_low_bound"}, int'(lo_cnt <= scen[i].max_low), 1);
    end

    wait_locked("locked_before_reset", 3 * FRAME_CLK);
    n = 0;
    while (!(gh == 5 && gv == 2) && n < 2 * FRAME_CLK) begin
      tick();
      n++;
    end
    check("reset_point", int'(gh == 5 && gv == 2), 1);
    check("video_on_before_reset", int'(video_on), 1);
    reset = 1'b1;
    tick();
    check("mid_rst_pixel_x", int'(pixel_x), 0);
    check("mid_rst_pixel_y", int'(pixel_y), 0);
    check("mid_rst_video_on", int'(video_on), 0);
    check("mid_rst_locked", int'(locked), 0);
    check("mid_rst_frame_start", int'(frame_start), 0);
    check("mid_rst_sync_err", int'(sync_err), 0);
    reset = 1'b0;
    err_cnt = 0;
    wait_locked("relock_after_reset", 3 * FRAME_CLK);
    check("no_err_after_reset", err_cnt, 0);
    track_two_frames("post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
